// File: rtl/hs_pkg.sv
// Shared types and constants for the high-score RAM responder.
package hs_pkg;

  typedef enum logic [1:0] {CPU, DRAIN, HS, RELEASE} hs_state_t;

  localparam logic [7:0] HS_OOW_DATA = 8'hFF;

endpackage

// File: rtl/hs_rd_pipe.sv
// Read-return delay line: tracks which RAM read beats belong to the engine and
// whether they were out of window, then registers the returned byte.
module hs_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       valid_i,
  input  logic       oow_i,
  input  logic [7:0] ram_dout_i,
  output logic [7:0] data_o
);
  import hs_pkg::*;

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] oow_q;
  logic [7:0]        data_q;

  // Stage RD_LAT-1 lines up with ram_dout for the address issued RD_LAT cycles ago.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      oow_q  <= '0;
      data_q <= 8'h00;
    end else begin
      vld_q[0] <= valid_i;
      oow_q[0] <= oow_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        oow_q[i] <= oow_q[i-1];
      end
      if (vld_q[RD_LAT-1]) begin
        data_q <= oow_q[RD_LAT-1] ? HS_OOW_DATA : ram_dout_i;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/hs_ram_responder.sv
// RAM-side responder for the high-score engine: arbitrates the single work RAM
// port between the CPU and the engine, stalling and draining the CPU on request.
module hs_ram_responder #(
  parameter int          AW        = 12,
  parameter logic [15:0] BASE      = 16'h8000,
  parameter int          RD_LAT    = 1,
  parameter int          DRAIN_MAX = 63
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          hs_pause,
  input  logic [15:0]   hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  output logic [7:0]    hs_data_out,
  output logic          hs_owned,
  output logic          hs_err,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  output logic          cpu_wait_n,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);
  import hs_pkg::*;

  localparam int            CW         = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

  hs_state_t     state_q, state_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic          err_q, err_d;
  logic [15:0]   off;
  logic          in_win;

  assign off    = hs_address - BASE;
  assign in_win = ~|(off >> AW);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    err_d       = err_q;
    if (hs_write && state_q != HS) err_d = 1'b1;
    case (state_q)
      CPU: begin
        if (hs_pause) state_d = DRAIN;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (!hs_pause) begin
          state_d = RELEASE;
        end else if (!cpu_cs) begin
          state_d = HS;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          // CPU never let go of the bus: take the port anyway and flag it.
          state_d = HS;
          err_d   = 1'b1;
        end
      end
      HS: begin
        if (!hs_pause) state_d = RELEASE;
      end
      RELEASE: state_d = CPU;
      default: state_d = CPU;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CPU;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
    end
  end

  // ram_we is also gated by reset so nothing is written while the core is held in reset.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = cpu_cs & cpu_we;
    if (state_q == HS) begin
      ram_addr = off[AW-1:0];
      ram_din  = hs_data_in;
      ram_we   = hs_write & in_win;
    end else if (state_q == RELEASE) begin
      ram_we = 1'b0;
    end
    ram_we = ram_we & reset_n;
  end

  assign cpu_wait_n = (state_q == CPU);
  assign hs_owned   = (state_q == HS);
  assign hs_err     = err_q;

  hs_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .valid_i    (state_q == HS),
    .oow_i      (~in_win),
    .ram_dout_i (ram_dout),
    .data_o     (hs_data_out)
  );

endmodule

// File: tb/tb_hs_ram_responder.sv
// Scoreboard bench for hs_ram_responder with a behavioural 4 KiB work RAM
// (read latency 1) and directed, hand-computed vectors.
module tb_hs_ram_responder;

  localparam int AW        = 12;
  localparam int DRAIN_MAX = 63;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          hs_pause;
  logic [15:0]   hs_address;
  logic [7:0]    hs_data_in;
  logic          hs_write;
  logic [7:0]    hs_data_out;
  logic          hs_owned;
  logic          hs_err;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_cs;
  logic          cpu_we;
  logic          cpu_wait_n;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } sbEntry_t;
  sbEntry_t sbQ[$];

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rdQ;

  hs_ram_responder #(.AW(AW), .BASE(16'h8000), .RD_LAT(1), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .hs_pause    (hs_pause),
    .hs_address  (hs_address),
    .hs_data_in  (hs_data_in),
    .hs_write    (hs_write),
    .hs_data_out (hs_data_out),
    .hs_owned    (hs_owned),
    .hs_err      (hs_err),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_cs      (cpu_cs),
    .cpu_we      (cpu_we),
    .cpu_wait_n  (cpu_wait_n),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rdQ <= mem[ram_addr];
  end
  assign ram_dout = rdQ;

  // Read-data monitor: compares hs_data_out when a queued read falls due.
  always @(negedge clk_sys) begin
    if (sbQ.size() > 0) begin
      if (sbQ[0].due == cyc) begin
        checks++;
        if (hs_data_out !== sbQ[0].data) begin
          errors++;
          $display("[TB] FAIL rd_data cyc %0d: got %h expected %h", cyc, hs_data_out, sbQ[0].data);
        end
        void'(sbQ.pop_front());
      end else if (sbQ[0].due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_missed cyc %0d: got none expected %h", cyc, sbQ[0].data);
        void'(sbQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic pause, input logic [15:0] addr,
                               input logic [7:0] din, input logic wr);
    hs_pause   = pause;
    hs_address = addr;
    hs_data_in = din;
    hs_write   = wr;
  endtask

  task automatic readExpect(input logic [15:0] addr, input logic [7:0] exp);
    applyStimulus(1'b1, addr, 8'h00, 1'b0);
    sbQ.push_back('{data: exp, due: cyc + 2});
    tick();
  endtask

  task automatic writeHs(input logic [15:0] addr, input logic [7:0] din,
                         input logic expWe, input logic [AW-1:0] expAddr);
    applyStimulus(1'b1, addr, din, 1'b1);
    settle();
    checkOutput("hs_wr_we", 16'(ram_we), 16'(expWe));
    if (expWe) begin
      checkOutput("hs_wr_addr", 16'(ram_addr), 16'(expAddr));
      checkOutput("hs_wr_din", 16'(ram_din), 16'(din));
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    reset_n  = 1'b0;
    cpu_addr = '0;
    cpu_din  = 8'h00;
    cpu_cs   = 1'b0;
    cpu_we   = 1'b0;
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    #1;
    checkOutput("rst_wait_n", 16'(cpu_wait_n), 16'h1);
    checkOutput("rst_owned", 16'(hs_owned), 16'h0);
    checkOutput("rst_ram_we", 16'(ram_we), 16'h0);
    checkOutput("rst_data_out", 16'(hs_data_out), 16'h00);
    checkOutput("rst_err", 16'(hs_err), 16'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Idle CPU bus takeover
    applyStimulus(1'b1, 16'h8000, 8'h00, 1'b0);
    settle();
    checkOutput("take_wait_n_0", 16'(cpu_wait_n), 16'h1);
    tick(); settle();
    checkOutput("take_wait_n_1", 16'(cpu_wait_n), 16'h0);
    checkOutput("take_owned_1", 16'(hs_owned), 16'h0);
    tick(); settle();
    checkOutput("take_owned_2", 16'(hs_owned), 16'h1);

    // Writes inside and outside the window, then read back
    writeHs(16'h8123, 8'hA5, 1'b1, 12'h123);
    writeHs(16'h8FFF, 8'h3C, 1'b1, 12'hFFF);
    writeHs(16'h8000, 8'h11, 1'b1, 12'h000);
    writeHs(16'h7FFF, 8'h77, 1'b0, 12'h000);
    writeHs(16'h9000, 8'h88, 1'b0, 12'h000);
    readExpect(16'h8123, 8'hA5);
    readExpect(16'h8FFF, 8'h3C);
    readExpect(16'h8000, 8'h11);
    readExpect(16'h9000, 8'hFF);
    readExpect(16'h7FFF, 8'hFF);
    readExpect(16'h8123, 8'hA5);
    settle();
    checkOutput("oow_no_err", 16'(hs_err), 16'h0);

    // Handback with a final engine write and a pending CPU write
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h055; cpu_din = 8'h5A;
    applyStimulus(1'b1, 16'h8300, 8'h00, 1'b0);
    settle();
    checkOutput("hs_cpu_gated", 16'(ram_we), 16'h0);
    tick();
    applyStimulus(1'b0, 16'h8200, 8'h42, 1'b1);
    settle();
    checkOutput("fall_wr_we", 16'(ram_we), 16'h1);
    checkOutput("fall_wr_addr", 16'(ram_addr), 16'h200);
    tick();
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    settle();
    checkOutput("rel_owned", 16'(hs_owned), 16'h0);
    checkOutput("rel_wait_n", 16'(cpu_wait_n), 16'h0);
    checkOutput("rel_ram_we", 16'(ram_we), 16'h0);
    tick(); settle();
    checkOutput("back_wait_n", 16'(cpu_wait_n), 16'h1);
    checkOutput("back_ram_we", 16'(ram_we), 16'h1);
    checkOutput("back_ram_addr", 16'(ram_addr), 16'h055);
    checkOutput("back_ram_din", 16'(ram_din), 16'h5A);
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;

    // Pause re-asserted during RELEASE goes through CPU first
    applyStimulus(1'b1, 16'h8000, 8'h00, 1'b0);
    tick(); tick(); settle();
    checkOutput("re_owned", 16'(hs_owned), 16'h1);
    applyStimulus(1'b0, 16'h8000, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h8000, 8'h00, 1'b0);
    settle();
    checkOutput("re_rel_wait_n", 16'(cpu_wait_n), 16'h0);
    tick(); settle();
    checkOutput("re_cpu_wait_n", 16'(cpu_wait_n), 16'h1);
    tick(); settle();
    checkOutput("re_drain_wait_n", 16'(cpu_wait_n), 16'h0);
    checkOutput("re_drain_owned", 16'(hs_owned), 16'h0);
    applyStimulus(1'b0, 16'h8000, 8'h00, 1'b0);
    tick(); tick();

    // Drain with a CPU cycle in flight for 10 cycles
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0AA; cpu_din = 8'h99;
    applyStimulus(1'b1, 16'h8000, 8'h00, 1'b0);
    tick(); settle();
    checkOutput("drain_wait_n", 16'(cpu_wait_n), 16'h0);
    checkOutput("drain_cpu_we", 16'(ram_we), 16'h1);
    checkOutput("drain_cpu_addr", 16'(ram_addr), 16'h0AA);
    for (int i = 0; i < 9; i++) begin
      tick(); settle();
      checkOutput("drain_hold", 16'(hs_owned), 16'h0);
    end
    cpu_cs = 1'b0; cpu_we = 1'b0;
    tick(); settle();
    checkOutput("drain_owned", 16'(hs_owned), 16'h1);
    checkOutput("drain_err", 16'(hs_err), 16'h0);
    readExpect(16'h80AA, 8'h99);
    readExpect(16'h8200, 8'h42);
    readExpect(16'h8055, 8'h5A);

    // Forced takeover: CPU never releases the bus
    applyStimulus(1'b0, 16'h8000, 8'h00, 1'b0);
    tick(); tick();
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h333;
    applyStimulus(1'b1, 16'h8000, 8'h00, 1'b0);
    begin
      int n;
      n = 0;
      while (!hs_owned && n < 200) begin
        tick(); settle();
        n++;
        if (n == DRAIN_MAX) checkOutput("force_err_before", 16'(hs_err), 16'h0);
      end
      checkOutput("force_owned", 16'(hs_owned), 16'h1);
      checkOutput("force_cycles", 16'(n), 16'(DRAIN_MAX + 1));
      checkOutput("force_err", 16'(hs_err), 16'h1);
    end
    cpu_cs = 1'b0;

    // Reset mid-HS with a write strobe active
    applyStimulus(1'b1, 16'h8010, 8'h5A, 1'b1);
    settle();
    checkOutput("prerst_we", 16'(ram_we), 16'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_ram_we", 16'(ram_we), 16'h0);
    checkOutput("midrst_wait_n", 16'(cpu_wait_n), 16'h1);
    checkOutput("midrst_owned", 16'(hs_owned), 16'h0);
    checkOutput("midrst_err", 16'(hs_err), 16'h0);
    checkOutput("midrst_data", 16'(hs_data_out), 16'h00);
    tick();
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    reset_n = 1'b1;
    checkOutput("midrst_mem", 16'(mem[12'h010]), 16'h00);
    tick();

    // Engine write while the CPU owns the port is dropped
    applyStimulus(1'b0, 16'h8020, 8'hEE, 1'b1);
    settle();
    checkOutput("drop_ram_we", 16'(ram_we), 16'h0);
    checkOutput("drop_err_pre", 16'(hs_err), 16'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    settle();
    checkOutput("drop_err", 16'(hs_err), 16'h1);
    tick(); settle();
    checkOutput("drop_err_sticky", 16'(hs_err), 16'h1);
    applyStimulus(1'b1, 16'h8000, 8'h00, 1'b0);
    tick(); tick();
    readExpect(16'h8020, 8'h00);

    for (int i = 0; i < 4; i++) tick();
    checkOutput("sb_empty", 16'(sbQ.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
